wb_rr_intercon: RTL and testbench
=================================

// Module: wb_rr_intercon
// PURPOSE
//  Parametrised shared-bus Wishbone interconnect: NUM_MASTERS masters, NUM_SLAVES slaves.
//  Round-robin arbitration with a locked grant, address-prefix decode, error on unmapped access.
//  Optional watchdog error on a hung slave.
//  Successor to the fixed 8x8 conbus; sits between the lm32 I/D ports plus DMA masters and the peripherals.
// PARAMETERS
//  NUM_MASTERS     4                      number of masters, 1..8
//  NUM_SLAVES      4                      number of slaves, 1..8
//  ADR_DEC_W       4                      number of top address bits compared for decode
//  SLAVE_ADDRS     {4'h7,4'h5,4'h4,4'h0}  packed prefixes; slice i (ADR_DEC_W bits) selects slave i
//  TIMEOUT_CYCLES  255                    watchdog limit in cycles (WB_INTERCON_TIMEOUT_EN only)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-high
//  m_adr_i    in   NM*32  master addresses, master i at [32i+31:32i]
//  m_dat_i    in   NM*32  master write data
//  m_sel_i    in   NM*4   master byte selects
//  m_we_i     in   NM     master write enables
//  m_cyc_i    in   NM     master cycle
//  m_stb_i    in   NM     master strobe
//  m_dat_o    out  32     read data, broadcast to all masters
//  m_ack_o    out  NM     ack, routed to the granted master only
//  m_err_o    out  NM     error, routed to the granted master only
//  s_adr_o    out  32     shared slave address
//  s_dat_o    out  32     shared slave write data
//  s_sel_o    out  4      shared slave byte selects
//  s_we_o     out  1      shared slave write enable
//  s_cyc_o    out  NS     per-slave cycle
//  s_stb_o    out  NS     per-slave strobe
//  s_dat_i    in   NS*32  slave read data
//  s_ack_i    in   NS     slave ack
//  s_err_i    in   NS     slave error
//  grant_o    out  NM     one-hot current grant (debug/LAC probe)
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state=IDLE; grant=0.
//   - last_grant=NM-1, so master 0 has first priority.
//  FSM IDLE -> OWN:
//   - In IDLE, if any m_cyc_i is high, search from last_grant+1 upward with wrap.
//   - The first requester found is registered into grant, and the FSM moves to OWN.
//   - Arbitration latency: 1 cycle; no slave strobe is driven in IDLE.
//  FSM OWN -> IDLE:
//   - The grant is held while the granted m_cyc_i stays high; it is locked across multiple stb.
//   - When the granted m_cyc_i is low, go to IDLE and set last_grant=grant.
//   - Other requesters are considered at the next edge (no combinational re-grant).
//  Forwarding in OWN (combinational from the granted master):
//   - The granted master's adr/dat/sel/we drive s_adr_o, s_dat_o, s_sel_o and s_we_o.
//   - Decode: slave i is hit if m_adr[31:32-ADR_DEC_W] equals SLAVE_ADDRS slice i.
//   - On multiple matches the lowest index wins.
//   - s_cyc_o[hit] = m_cyc; s_stb_o[hit] = m_stb; all other slaves see 0.
//   - m_dat_o = s_dat_i[hit]; m_ack_o[g] = s_ack_i[hit]; m_err_o[g] = s_err_i[hit].
//   - Zero added latency.
//   - ack/err from slaves that are not selected are ignored.
//  Unmapped address:
//   - No s_cyc_o/s_stb_o is asserted.
//   - A registered 1-cycle m_err_o[g] pulse is issued one cycle after stb is first seen.
//   - m_err_o is never asserted in back-to-back cycles; stb must drop or re-present before another err.
//  Outside OWN: m_ack_o, m_err_o, s_cyc_o and s_stb_o are all 0.
//  Shared outputs in IDLE: s_adr_o, s_dat_o, s_sel_o and s_we_o are driven from master 0 (don't-care).
//  Simultaneous cycle end: if the granted master drops cyc in the same cycle another raises it, normal IDLE arbitration follows.
//  Reset mid-transfer: all outputs are forced 0 asynchronously and the transfer is abandoned; no ack or err is issued.
// CONFIGURATION
//  WB_INTERCON_TIMEOUT_EN defined:
//   - An 8..16-bit counter clears on ack, err, stb low, or leaving OWN.
//   - Otherwise it increments each OWN cycle with stb high.
//   - When count==TIMEOUT_CYCLES: assert m_err_o[g] for 1 cycle.
//   - In that same cycle, force s_cyc_o/s_stb_o to 0 and clear the counter.
//   - A late slave ack is ignored until stb is re-presented.
//  WB_INTERCON_TIMEOUT_EN undefined: no counter; a hung slave stalls the bus indefinitely.
//   - TIMEOUT_CYCLES is unused.
// TESTING
//  1. M0 read 0x7000_0010; slave 3 acks 2 cycles after stb with dat 0xCAFEF00D.
//     -> m_ack_o[0] in the same cycle as s_ack_i[3]; m_dat_o=0xCAFEF00D; s_cyc_o=4'b1000.
//  2. After reset, M0 and M2 raise cyc together and repeat one single-beat cycle each, 4 times.
//     -> grant order 0,2,0,2; 1 idle arbitration cycle between owners.
//  3. M1 write to 0xF000_0000 (unmapped).
//     -> s_cyc_o stays 0; m_err_o[1]=1 for exactly one cycle, one cycle after stb.
//  4. M1 holds cyc for 3 stb beats while M0 requests.
//     -> M0 is granted only after M1 drops cyc; grant_o goes 0010 -> 0000 -> 0001.
//  5. TIMEOUT_EN, TIMEOUT_CYCLES=15, slave 0 never acks.
//     -> m_err_o pulses in the 16th stb cycle; s_stb_o[0] is 0 in that cycle.
//     -> Without the macro: no err after 1000 cycles.
//  6. Reset asserted while M2 is mid-transfer.
//     -> all outputs are 0 with no clock edge; after release a request from M0 and M3 is granted to M0.

Source files
------------

// File: rtl/wb_rr_intercon_if.sv
// Signal bundle for wb_rr_intercon: per-master request/response vectors,
// the shared slave bus, per-slave responses and the grant probe.
// NM = number of masters, NS = number of slaves.
interface wb_rr_intercon_if #(
    parameter int NM = 4,
    parameter int NS = 4
);
    // Master side
    logic [NM*32-1:0] m_adr_i;
    logic [NM*32-1:0] m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i;
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;

    // Shared slave bus
    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;
    logic [NS-1:0]    s_err_i;

    // Debug probe
    logic [NM-1:0]    grant_o;

    // Interconnect's view: it masters the shared slave bus.
    modport master (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output grant_o
    );

    // View of the attached agents (bus masters and slaves together).
    modport slave (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  grant_o
    );
endinterface

// File: rtl/wb_rr_intercon.sv
// Shared-bus Wishbone interconnect: NUM_MASTERS masters, NUM_SLAVES slaves.
// Round-robin arbitration with a grant locked for the whole master cycle,
// address-prefix decode, and an error pulse for unmapped addresses.
// Optional hung-slave watchdog: define WB_INTERCON_TIMEOUT_EN.
module wb_rr_intercon #(
    parameter int                                NUM_MASTERS    = 4,
    parameter int                                NUM_SLAVES     = 4,
    parameter int                                ADR_DEC_W      = 4,
    parameter logic [NUM_SLAVES*ADR_DEC_W-1:0]   SLAVE_ADDRS    = {4'h7, 4'h5, 4'h4, 4'h0},
    parameter int                                TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              reset,
    wb_rr_intercon_if.master bus
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic                   uerr_q, uerr_d;

    logic                   own;
    logic [NUM_MASTERS-1:0] sel_oh;
    logic [31:0]            g_adr;
    logic [31:0]            g_dat;
    logic [3:0]             g_sel;
    logic                   g_we;
    logic [IDX_W-1:0]       g_idx;
    logic                   g_cyc;
    logic                   g_stb;
    logic [NUM_SLAVES-1:0]  hit_oh;
    logic                   miss;
    logic [31:0]            hit_dat;
    logic                   hit_ack;
    logic                   hit_err;
    logic                   to_fire;

    assign own    = (state_q == ST_OWN);
    // While idle the shared bus shows master 0; grant_q is zero then.
    assign sel_oh = own ? grant_q : NUM_MASTERS'(1);
    assign g_cyc  = |(bus.m_cyc_i & grant_q);
    assign g_stb  = |(bus.m_stb_i & grant_q);
    assign miss   = ~|hit_oh;

    // Multiplex the selected master's request onto the shared bus.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel_oh[i]) begin
                g_adr = bus.m_adr_i[32*i +: 32];
                g_dat = bus.m_dat_i[32*i +: 32];
                g_sel = bus.m_sel_i[4*i +: 4];
                g_we  = bus.m_we_i[i];
                g_idx = IDX_W'(i);
            end
        end
    end

    // Address-prefix decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_oh = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (g_adr[31 -: ADR_DEC_W] == SLAVE_ADDRS[ADR_DEC_W*i +: ADR_DEC_W]) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // Pick the selected slave's response; other slaves' ack/err are ignored.
    always_comb begin
        hit_dat = '0;
        hit_ack = 1'b0;
        hit_err = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit_oh[i]) begin
                hit_dat = bus.s_dat_i[32*i +: 32];
                hit_ack = bus.s_ack_i[i];
                hit_err = bus.s_err_i[i];
            end
        end
    end

    // Arbiter next state: round-robin search in IDLE, hold the grant in OWN.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = ST_OWN;
                    grant_d = '0;
                    // Walk distances from far to near so the nearest requester after last_q overwrites.
                    for (int off = NUM_MASTERS; off >= 1; off--) begin
                        for (int i = 0; i < NUM_MASTERS; i++) begin
                            if (((int'(last_q) + off) % NUM_MASTERS == i) && bus.m_cyc_i[i]) begin
                                grant_d    = '0;
                                grant_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_OWN: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = g_idx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Unmapped strobe: one registered error pulse, never two in a row.
    assign uerr_d = own && g_stb && miss && !uerr_q;

    // Arbiter state, grant, round-robin pointer and unmapped-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            uerr_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            uerr_q  <= uerr_d;
        end
    end

`ifdef WB_INTERCON_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_fire = own && g_stb && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Watchdog count of strobed cycles still waiting for a slave response.
    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!own || !g_stb || hit_ack || hit_err || uerr_q || to_fire) begin
            to_cnt_d = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    // Drive both sides of the bus; only OWN forwards handshakes, reset blanks everything.
    always_comb begin
        bus.s_adr_o = g_adr;
        bus.s_dat_o = g_dat;
        bus.s_sel_o = g_sel;
        bus.s_we_o  = g_we;
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (own) begin
            bus.m_dat_o = hit_dat;
            // A watchdog abort withdraws the slave cycle and swallows a late ack.
            if (!to_fire) begin
                bus.s_cyc_o = hit_oh & {NUM_SLAVES{g_cyc}};
                bus.s_stb_o = hit_oh & {NUM_SLAVES{g_stb}};
                bus.m_ack_o = grant_q & {NUM_MASTERS{hit_ack}};
            end
            bus.m_err_o = grant_q & {NUM_MASTERS{hit_err || uerr_q || to_fire}};
        end
        if (reset) begin
            bus.s_adr_o = '0;
            bus.s_dat_o = '0;
            bus.s_sel_o = '0;
            bus.s_we_o  = 1'b0;
        end
    end

    assign bus.grant_o = grant_q;

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Self-checking bench for wb_rr_intercon (4 masters, 4 slaves, prefixes 0/4/5/7).
// Table of decode/forwarding vectors under a locked M0 grant, then hand-written
// sequences for arbitration, unmapped error, grant locking, watchdog and reset.
module tb_wb_rr_intercon;

    localparam int NM = 4;
    localparam int NS = 4;

    typedef struct {
        logic [31:0] adr;
        logic        stb;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [3:0]  exp_cyc;
        logic [3:0]  exp_stb;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_err;
        logic [31:0] exp_dat;
        logic        chk_dat;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_rr_intercon_if #(.NM(NM), .NS(NS)) bus ();

    wb_rr_intercon #(
        .NUM_MASTERS   (NM),
        .NUM_SLAVES    (NS),
        .ADR_DEC_W     (4),
        .SLAVE_ADDRS   (16'h7540),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Slave acks: manual per-slave value, optionally plus an immediate ack to any strobe.
    logic [NS-1:0] ack_man;
    logic          auto_ack;
    assign bus.s_ack_i = ack_man | (auto_ack ? bus.s_stb_o : '0);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m(input int m, input logic [31:0] adr, input logic cyc, input logic stb,
                         input logic we);
        bus.m_adr_i[32*m +: 32] = adr;
        bus.m_cyc_i[m]          = cyc;
        bus.m_stb_i[m]          = stb;
        bus.m_we_i[m]           = we;
    endtask

    task automatic idle_inputs();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.s_err_i = '0;
        ack_man     = '0;
        auto_ack    = 1'b0;
        for (int i = 0; i < NS; i++) bus.s_dat_i[32*i +: 32] = 32'hD000_0000 | 32'(i);
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Bound on the whole run.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [3:0]  exp_order[4];
        int          done[NM];
        logic        pend[NM];
        logic [3:0]  prev_g;
        int          idle_run;
        int          n_grants;
        int          err_seen;
        logic [3:0]  pat[4];

        //            adr           stb   ack      err      cyc      stb      m_ack    m_err    dat            chk
        vecs[0] = '{32'h0000_0100, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 32'hD000_0000, 1'b1};
        vecs[1] = '{32'h4000_0004, 1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 4'b0000, 32'hD000_0001, 1'b1};
        vecs[2] = '{32'h5123_0000, 1'b1, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 32'hD000_0002, 1'b1};
        vecs[3] = '{32'h7FFF_FFFC, 1'b1, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 32'hD000_0003, 1'b1};
        vecs[4] = '{32'h5000_0000, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 32'hD000_0002, 1'b1};
        vecs[5] = '{32'hF000_0000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h7000_0000, 1'b1, 4'b1000, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000, 32'hD000_0003, 1'b1};
        vecs[7] = '{32'h1000_0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0};

        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0100;
        exp_order[2] = 4'b0001;
        exp_order[3] = 4'b0100;

        // ---- Reset state ----
        idle_inputs();
        reset = 1'b1;
        tick();
        check("rst_grant", 32'(bus.grant_o), 32'h0);
        check("rst_s_cyc", 32'(bus.s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(bus.s_stb_o), 32'h0);
        check("rst_m_ack", 32'(bus.m_ack_o), 32'h0);
        check("rst_m_err", 32'(bus.m_err_o), 32'h0);
        reset = 1'b0;

        // ---- Single read from M0 to slave 3, ack two cycles after stb ----
        tick();
        set_m(0, 32'h7000_0010, 1'b1, 1'b1, 1'b0);
        #1;
        check("t1_idle_grant", 32'(bus.grant_o), 32'h0);
        check("t1_idle_stb", 32'(bus.s_stb_o), 32'h0);
        tick();
        #1;
        check("t1_grant", 32'(bus.grant_o), 32'h1);
        check("t1_s_cyc", 32'(bus.s_cyc_o), 32'h8);
        check("t1_no_early_ack", 32'(bus.m_ack_o), 32'h0);
        tick();
        tick();
        bus.s_dat_i[96 +: 32] = 32'hCAFE_F00D;
        ack_man = 4'b1000;
        #1;
        check("t1_m_ack", 32'(bus.m_ack_o), 32'h1);
        check("t1_m_dat", bus.m_dat_o, 32'hCAFE_F00D);
        check("t1_s_cyc_ack", 32'(bus.s_cyc_o), 32'h8);
        ack_man = '0;
        set_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.s_dat_i[96 +: 32] = 32'hD000_0003;
        tick();
        #1;
        check("t1_release", 32'(bus.grant_o), 32'h0);

        // ---- Decode / forwarding table with M0 holding the bus ----
        tick();
        set_m(0, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        tick();
        for (int v = 0; v < 8; v++) begin
            bus.m_adr_i[31:0] = vecs[v].adr;
            bus.m_stb_i[0]    = vecs[v].stb;
            ack_man           = vecs[v].ack;
            bus.s_err_i       = vecs[v].err;
            #1;
            check($sformatf("vec%0d_s_cyc", v), 32'(bus.s_cyc_o), 32'(vecs[v].exp_cyc));
            check($sformatf("vec%0d_s_stb", v), 32'(bus.s_stb_o), 32'(vecs[v].exp_stb));
            check($sformatf("vec%0d_m_ack", v), 32'(bus.m_ack_o), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d_m_err", v), 32'(bus.m_err_o), 32'(vecs[v].exp_err));
            if (vecs[v].chk_dat) check($sformatf("vec%0d_m_dat", v), bus.m_dat_o, vecs[v].exp_dat);
            tick();
        end
        ack_man     = '0;
        bus.s_err_i = '0;
        set_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // ---- M0 and M2 alternate, two single-beat cycles each ----
        reset_dut();
        auto_ack = 1'b1;
        tick();
        set_m(0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        set_m(2, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
        for (int m = 0; m < NM; m++) begin
            done[m] = 0;
            pend[m] = 1'b0;
        end
        prev_g   = '0;
        idle_run = 0;
        n_grants = 0;
        for (int c = 0; c < 40 && !(done[0] == 2 && done[2] == 2); c++) begin
            #1;
            if (bus.grant_o != 4'b0000 && prev_g == 4'b0000) begin
                if (n_grants < 4)
                    check($sformatf("t2_order%0d", n_grants), 32'(bus.grant_o), 32'(exp_order[n_grants]));
                check($sformatf("t2_gap%0d", n_grants), 32'(idle_run), 32'd1);
                n_grants++;
            end
            idle_run = (bus.grant_o == 4'b0000) ? idle_run + 1 : 0;
            prev_g   = bus.grant_o;
            for (int m = 0; m < NM; m += 2) begin
                if (bus.m_ack_o[m]) begin
                    done[m]++;
                    bus.m_cyc_i[m] = 1'b0;
                    bus.m_stb_i[m] = 1'b0;
                    pend[m]        = (done[m] < 2);
                end
            end
            tick();
            for (int m = 0; m < NM; m += 2) begin
                if (pend[m]) begin
                    bus.m_cyc_i[m] = 1'b1;
                    bus.m_stb_i[m] = 1'b1;
                    pend[m]        = 1'b0;
                end
            end
        end
        check("t2_complete", 32'(done[0] == 2 && done[2] == 2), 32'd1);
        check("t2_grants", 32'(n_grants), 32'd4);
        auto_ack = 1'b0;
        idle_inputs();
        tick();

        // ---- M1 unmapped write, stb held: error pulses never back-to-back ----
        tick();
        set_m(1, 32'hF000_0000, 1'b1, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k == 0) check("t3_grant", 32'(bus.grant_o), 32'h2);
            check($sformatf("t3_err%0d", k), 32'(bus.m_err_o), (k % 2 == 1) ? 32'h2 : 32'h0);
            check($sformatf("t3_quiet%0d", k), 32'(bus.s_cyc_o | bus.s_stb_o), 32'h0);
            tick();
        end
        #1;
        check("t3_err_end", 32'(bus.m_err_o), 32'h0);
        set_m(1, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // ---- M1 keeps the lock across stb gaps while M0 waits ----
        auto_ack = 1'b1;
        pat[0] = 4'd1;
        pat[1] = 4'd0;
        pat[2] = 4'd1;
        pat[3] = 4'd1;
        tick();
        set_m(1, 32'h0000_0040, 1'b1, 1'b1, 1'b0);
        tick();
        set_m(0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.m_stb_i[1] = pat[k][0];
            #1;
            check($sformatf("t4_lock%0d", k), 32'(bus.grant_o), 32'h2);
            check($sformatf("t4_ack%0d", k), 32'(bus.m_ack_o), pat[k][0] ? 32'h2 : 32'h0);
            if (k == 3) set_m(1, 32'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        #1;
        check("t4_idle", 32'(bus.grant_o), 32'h0);
        tick();
        #1;
        check("t4_m0_grant", 32'(bus.grant_o), 32'h1);
        set_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
        auto_ack = 1'b0;
        tick();

        // ---- Hung slave 0 ----
        tick();
        set_m(0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        tick();
`ifdef WB_INTERCON_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            #1;
            check($sformatf("t5_err%0d", k), 32'(bus.m_err_o), (k == 16) ? 32'h1 : 32'h0);
            check($sformatf("t5_stb%0d", k), 32'(bus.s_stb_o), (k == 16) ? 32'h0 : 32'h1);
            if (k == 16) set_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
            tick();
        end
`else
        err_seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            #1;
            if (bus.m_err_o != 4'b0000) err_seen++;
            tick();
        end
        check("t5_no_err", 32'(err_seen), 32'd0);
        #1;
        check("t5_still_stb", 32'(bus.s_stb_o), 32'h1);
        set_m(0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
`endif
        tick();

        // ---- Reset during an M2 transfer, then M0 beats M3 ----
        set_m(0, 32'h5555_0000, 1'b0, 1'b0, 1'b1);
        bus.m_dat_i[31:0] = 32'hA5A5_A5A5;
        bus.m_sel_i[3:0]  = 4'hF;
        set_m(2, 32'h4000_0000, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        ack_man = 4'b0010;
        #1;
        check("t6_pre_ack", 32'(bus.m_ack_o), 32'h4);
        check("t6_pre_cyc", 32'(bus.s_cyc_o), 32'h2);
        reset = 1'b1;
        #1;
        check("t6_grant", 32'(bus.grant_o), 32'h0);
        check("t6_s_cyc", 32'(bus.s_cyc_o), 32'h0);
        check("t6_s_stb", 32'(bus.s_stb_o), 32'h0);
        check("t6_m_ack", 32'(bus.m_ack_o), 32'h0);
        check("t6_m_err", 32'(bus.m_err_o), 32'h0);
        check("t6_m_dat", bus.m_dat_o, 32'h0);
        check("t6_s_adr", bus.s_adr_o, 32'h0);
        check("t6_s_dat", bus.s_dat_o, 32'h0);
        check("t6_s_sel_we", {27'h0, bus.s_we_o, bus.s_sel_o}, 32'h0);
        idle_inputs();
        tick();
        reset = 1'b0;
        set_m(0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        set_m(3, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
        #1;
        check("t6_idle", 32'(bus.grant_o), 32'h0);
        tick();
        #1;
        check("t6_first_prio", 32'(bus.grant_o), 32'h1);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
